// File: rtl/io_ddr_pkg.sv
// Shared definitions for the io_ddr pad buffer: technology names and the
// mapping from the TARGET string to an enum.
package io_ddr_pkg;

  localparam string TARGET_ALTERA  = "ALTERA";
  localparam string TARGET_XILINX  = "XILINX";
  localparam string TARGET_GENERIC = "GENERIC";

  typedef enum logic [1:0] {
    TGT_ALTERA  = 2'd0,
    TGT_XILINX  = 2'd1,
    TGT_GENERIC = 2'd2
  } target_e;

  // Anything unrecognised falls back to the behavioural cell.
  function automatic target_e target_of(input string t);
    if (t == TARGET_ALTERA) return TGT_ALTERA;
    if (t == TARGET_XILINX) return TGT_XILINX;
    return TGT_GENERIC;
  endfunction

endpackage

// File: rtl/io_ddr_cell.sv
// One-bit DDR pad cell: rising/falling transmit registers, tri-state pad mux,
// and rising/falling capture. IODDR_INPUT_REG_EN adds one more receive stage.
module io_ddr_cell
  import io_ddr_pkg::*;
#(
  parameter target_e TGT = TGT_GENERIC
) (
  input  logic clk,
  input  logic rst,
  input  logic d_rise,
  input  logic d_fall,
  input  logic oe_r,
  inout  wire  dq,
  output logic q_rise,
  output logic q_fall
);

  logic h_r, l_r, l_n;
  logic rh, rl;
  logic q_rise_r, q_fall_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_r <= 1'b0;
      l_r <= 1'b0;
    end else begin
      h_r <= d_rise;
      l_r <= d_fall;
    end
  end

  // Falling beat is re-timed onto the negedge so the low phase never glitches.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) l_n <= 1'b0;
    else     l_n <= l_r;
  end

  // Vendor DDIO primitives would replace the behavioural mux in g_vendor;
  // both branches are cycle-equivalent.
  if (TGT == TGT_GENERIC) begin : g_generic
    assign dq = oe_r ? (clk ? h_r : l_n) : 1'bz;
  end else begin : g_vendor
    assign dq = oe_r ? (clk ? h_r : l_n) : 1'bz;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rh <= 1'b0;
    else     rh <= dq;
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) rl <= 1'b0;
    else     rl <= dq;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_rise_r <= 1'b0;
      q_fall_r <= 1'b0;
    end else begin
      q_rise_r <= rh;
      q_fall_r <= rl;
    end
  end

`ifdef IODDR_INPUT_REG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_rise <= 1'b0;
      q_fall <= 1'b0;
    end else begin
      q_rise <= q_rise_r;
      q_fall <= q_fall_r;
    end
  end
`else
  assign q_rise = q_rise_r;
  assign q_fall = q_fall_r;
`endif

endmodule

// File: rtl/io_ddr.sv
// Bidirectional DDR pad buffer for HyperBus DQ/RWDS: WIDTH cells sharing one
// registered output enable. Optional extra receive stage via IODDR_INPUT_REG_EN.
module io_ddr
  import io_ddr_pkg::*;
#(
  parameter string TARGET = "ALTERA",
  parameter int    WIDTH  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2*WIDTH-1:0] dataw,
  output logic [2*WIDTH-1:0] datar,
  inout  wire  [WIDTH-1:0]   dq,
  input  logic               oe
);

  localparam target_e TGT = target_of(TARGET);

  logic oe_r;

  // Enable is posedge-only so every drive window is a full high+low pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) oe_r <= 1'b0;
    else     oe_r <= oe;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    io_ddr_cell #(.TGT(TGT)) u_cell (
      .clk    (clk),
      .rst    (rst),
      .d_rise (dataw[WIDTH+i]),
      .d_fall (dataw[i]),
      .oe_r   (oe_r),
      .dq     (dq[i]),
      .q_rise (datar[WIDTH+i]),
      .q_fall (datar[i])
    );
  end

endmodule

// File: tb/tb_io_ddr.sv
// Directed bench for io_ddr: an 8-bit DQ instance and a 1-bit RWDS instance.
module tb_io_ddr;

`ifdef IODDR_INPUT_REG_EN
  localparam int RX_LAT = 2;
`else
  localparam int RX_LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] dataw8;
  logic [15:0] datar8;
  logic        oe8;
  logic [1:0]  dataw1;
  logic [1:0]  datar1;
  logic        oe1;
  wire  [7:0]  dq8;
  wire  [0:0]  dq1;
  logic        tb_en8, tb_en1;
  logic [7:0]  tb_d8;
  logic        tb_d1;

  int checks = 0;
  int failures = 0;

  assign dq8 = tb_en8 ? tb_d8 : 8'hzz;
  assign dq1 = tb_en1 ? tb_d1 : 1'bz;

  always #5 clk = ~clk;

  io_ddr #(.TARGET("ALTERA"), .WIDTH(8)) u_dq (
    .clk(clk), .rst(rst), .dataw(dataw8), .datar(datar8), .dq(dq8), .oe(oe8)
  );

  io_ddr #(.TARGET("GENERIC"), .WIDTH(1)) u_rwds (
    .clk(clk), .rst(rst), .dataw(dataw1), .datar(datar1), .dq(dq1), .oe(oe1)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] r8;
    logic [7:0] f8;
    logic       r1;
    logic       f1;
    logic [15:0] e8;
    logic [1:0]  e1;
  } rx_vec_t;

  rx_vec_t rx_tab[3];

  initial begin
    rx_tab[0] = '{8'h12, 8'h34, 1'b1, 1'b1, 16'h1234, 2'b11};
    rx_tab[1] = '{8'hF0, 8'h0F, 1'b0, 1'b1, 16'hF00F, 2'b01};
    rx_tab[2] = '{8'h00, 8'hFF, 1'b1, 1'b0, 16'h00FF, 2'b10};

    rst = 1'b1; oe8 = 1'b0; oe1 = 1'b0; dataw8 = '0; dataw1 = '0;
    tb_en8 = 1'b0; tb_en1 = 1'b0; tb_d8 = '0; tb_d1 = 1'b0;

    // reset state
    #12;
    chk("rst_datar8", datar8, 16'h0000);
    chk("rst_datar1", datar1, 2'b00);
    chk("rst_dq8_z", dq8 === 8'hzz, 1);
    chk("rst_dq1_z", dq1 === 1'bz, 1);
    @(negedge clk); #1 rst = 1'b0;

    // single word transmit plus RWDS transmit
    @(negedge clk); #1 oe8 = 1'b1; dataw8 = 16'hA55A; oe1 = 1'b1; dataw1 = 2'b10;
    @(posedge clk); #2;
    chk("tx_hi", dq8, 8'hA5);
    chk("tx1_hi", dq1, 1'b1);
    dataw8 = 16'h1122; dataw1 = 2'b01;
    @(negedge clk); #2;
    chk("tx_lo", dq8, 8'h5A);
    chk("tx1_lo", dq1, 1'b0);

    // gapless burst, then drop enable
    @(posedge clk); #2;
    chk("burst_11", dq8, 8'h11);
    chk("tx1_hi2", dq1, 1'b0);
    dataw8 = 16'h3344; oe1 = 1'b0;
    @(negedge clk); #2;
    chk("burst_22", dq8, 8'h22);
    chk("tx1_lo2", dq1, 1'b1);
    @(posedge clk); #2;
    chk("burst_33", dq8, 8'h33);
    chk("tx1_off_z", dq1 === 1'bz, 1);
    dataw8 = 16'h5566;
    @(negedge clk); #2;
    chk("burst_44", dq8, 8'h44);
    @(posedge clk); #2;
    chk("burst_55", dq8, 8'h55);
    oe8 = 1'b0;
    @(negedge clk); #2;
    chk("burst_66", dq8, 8'h66);
    @(posedge clk); #2;
    chk("burst_off_hi_z", dq8 === 8'hzz, 1);
    @(negedge clk); #2;
    chk("burst_off_lo_z", dq8 === 8'hzz, 1);

    // reset asserted mid-drive
    #1 oe8 = 1'b1; dataw8 = 16'hFFFF;
    @(posedge clk); #2;
    chk("mid_drive", dq8, 8'hFF);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_z", dq8 === 8'hzz, 1);
    chk("mid_rst_datar", datar8, 16'h0000);
    @(negedge clk); #1 rst = 1'b0; oe8 = 1'b0; dataw8 = '0;
    @(posedge clk); #2;
    chk("post_rst_hi_z", dq8 === 8'hzz, 1);
    @(negedge clk); #2;
    chk("post_rst_lo_z", dq8 === 8'hzz, 1);

    // receive: bench drives both edges with the DUT tri-stated
    tb_en8 = 1'b1; tb_en1 = 1'b1;
    foreach (rx_tab[k]) begin
      tb_d8 = rx_tab[k].r8; tb_d1 = rx_tab[k].r1;
      @(posedge clk); #2;
      tb_d8 = rx_tab[k].f8; tb_d1 = rx_tab[k].f1;
      repeat (RX_LAT) @(posedge clk);
      #2;
      chk($sformatf("rx8_%0d", k), datar8, rx_tab[k].e8);
      chk($sformatf("rx1_%0d", k), datar1, rx_tab[k].e1);
    end
    tb_en8 = 1'b0; tb_en1 = 1'b0;

    // turnaround: drive one word, then release and let the bench take over
    @(negedge clk); #1 oe8 = 1'b1; dataw8 = 16'h1357;
    @(posedge clk); #2;
    chk("ta_drive", dq8, 8'h13);
    oe8 = 1'b0; dataw8 = 16'hDEAD;
    @(posedge clk); #2;
    chk("ta_release_z", dq8 === 8'hzz, 1);
    #1 tb_en8 = 1'b1; tb_d8 = 8'hC3;
    @(negedge clk); #2;
    chk("ta_no_contention", dq8, 8'hC3);
    tb_d8 = 8'h96;
    repeat (RX_LAT) @(posedge clk);
    #2;
    chk("ta_rx_fall", datar8[7:0], 8'hC3);
    @(posedge clk); #2;
    chk("ta_rx_word", datar8, 16'h9696);
    tb_en8 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
